// File: rtl/vga_scan_out_pkg.sv
// Shared VGA timing constants, colour keys, colour-field slices and the stage-1 flag bundle.
package vga_scan_out_pkg;

  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam int CLK_DIV = 4;
  localparam int ROM_LAT = 2;

  localparam logic [11:0] TRANSPARENT = 12'hF0F;
  localparam logic [11:0] BG_COLOR    = 12'h000;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  // Sync flags are kept active-high here so an all-zero reset means "no sync".
  typedef struct packed {
    logic active;
    logic not_blank;
    logic hs;
    logic vs;
  } s1_t;

  function automatic logic [11:0] dim(input logic [11:0] c);
    return {1'b0, c[R_HI:R_LO+1], 1'b0, c[G_HI:G_LO+1], 1'b0, c[B_HI:B_LO+1]};
  endfunction

endpackage

// File: rtl/vga_scan_out_timing.sv
// Pixel-rate divider, raster counters, frame tick and raw active/sync decode.
module vga_timing #(
  parameter int CLK_DIV = vga_scan_out_pkg::CLK_DIV,
  parameter int H_ACT   = vga_scan_out_pkg::H_ACT,
  parameter int H_FP    = vga_scan_out_pkg::H_FP,
  parameter int H_SYNC  = vga_scan_out_pkg::H_SYNC,
  parameter int H_BP    = vga_scan_out_pkg::H_BP,
  parameter int V_ACT   = vga_scan_out_pkg::V_ACT,
  parameter int V_FP    = vga_scan_out_pkg::V_FP,
  parameter int V_SYNC  = vga_scan_out_pkg::V_SYNC,
  parameter int V_BP    = vga_scan_out_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       frame_start,
  output logic       active,
  output logic       hs_n,
  output logic       vs_n
);
  import vga_scan_out_pkg::*;

  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          fs_q, fs_d;

  assign pix_en = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d = pix_en ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    fs_d  = 1'b0;
    if (pix_en) begin
      if (h_q == 10'(HT - 1)) begin
        h_d = '0;
        if (v_q == 10'(VT - 1)) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fs_q  <= fs_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign frame_start = fs_q;
  assign active      = (h_q < 10'(H_ACT)) && (v_q < 10'(V_ACT));
  assign hs_n        = !((h_q >= 10'(H_ACT + H_FP)) && (h_q <= 10'(H_ACT + H_FP + H_SYNC - 1)));
  assign vs_n        = !((v_q >= 10'(V_ACT + V_FP)) && (v_q <= 10'(V_ACT + V_FP + V_SYNC - 1)));

endmodule

// File: rtl/vga_scan_out.sv
// Scan-out top: raster timing, ROM address stage, colour mux stage and VGA pin drive.
module vga_scan_out #(
  parameter int CLK_DIV = vga_scan_out_pkg::CLK_DIV,
  parameter int ROM_LAT = vga_scan_out_pkg::ROM_LAT,
  parameter int H_ACT   = vga_scan_out_pkg::H_ACT,
  parameter int H_FP    = vga_scan_out_pkg::H_FP,
  parameter int H_SYNC  = vga_scan_out_pkg::H_SYNC,
  parameter int H_BP    = vga_scan_out_pkg::H_BP,
  parameter int V_ACT   = vga_scan_out_pkg::V_ACT,
  parameter int V_FP    = vga_scan_out_pkg::V_FP,
  parameter int V_SYNC  = vga_scan_out_pkg::V_SYNC,
  parameter int V_BP    = vga_scan_out_pkg::V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isDark,
  input  logic [16:0] pixel_addr,
  input  logic        notBlank,
  input  logic [11:0] rom_data,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic [16:0] rom_addr,
  output logic        pix_en,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  import vga_scan_out_pkg::*;

  // ROM data must settle inside one pixel period.
  if (ROM_LAT > CLK_DIV - 1) begin : g_lat_chk
    $error("vga_scan_out: ROM_LAT must be <= CLK_DIV-1");
  end

  logic active, hs_n, vs_n;

  vga_timing #(
    .CLK_DIV(CLK_DIV),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_start (frame_start),
    .active      (active),
    .hs_n        (hs_n),
    .vs_n        (vs_n)
  );

  s1_t         s1_q, s1_d;
  logic [16:0] addr_q, addr_d;
  logic [11:0] rgb_q, rgb_d, colour;
  logic        hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    if (!s1_q.active)
      colour = '0;
    else if (!s1_q.not_blank || rom_data == TRANSPARENT)
      colour = BG_COLOR;
    else
      colour = rom_data;

    addr_d = addr_q;
    s1_d   = s1_q;
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (pix_en) begin
      addr_d = pixel_addr;
      s1_d   = '{active: active, not_blank: notBlank, hs: !hs_n, vs: !vs_n};
      rgb_d  = isDark ? dim(colour) : colour;
      hs_d   = !s1_q.hs;
      vs_d   = !s1_q.vs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      s1_q   <= '0;
      rgb_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      addr_q <= addr_d;
      s1_q   <= s1_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign rom_addr = addr_q;
  assign vgaRed   = rgb_q[R_HI:R_LO];
  assign vgaGreen = rgb_q[G_HI:G_LO];
  assign vgaBlue  = rgb_q[B_HI:B_LO];
  assign hsync    = hs_q;
  assign vsync    = vs_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomized bench for vga_scan_out on a shrunken raster, checked against a pixel-index model.
module tb_vga_scan_out;
  localparam int CD = 4;
  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0, rst = 1'b1, isDark = 1'b0, notBlank = 1'b0;
  logic [16:0] pixel_addr = '0;
  logic [11:0] rom_data;
  logic [9:0]  h_cnt, v_cnt;
  logic [16:0] rom_addr;
  logic        pix_en, hsync, vsync, frame_start;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  vga_scan_out #(
    .CLK_DIV(CD), .ROM_LAT(2),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .isDark(isDark), .pixel_addr(pixel_addr),
    .notBlank(notBlank), .rom_data(rom_data), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .rom_addr(rom_addr), .pix_en(pix_en), .vgaRed(vgaRed), .vgaGreen(vgaGreen),
    .vgaBlue(vgaBlue), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // ROM model: data = addr[11:0], two clk after the address changes
  logic [16:0] rl1 = '0, rl2 = '0;
  always @(posedge clk) begin
    rl1 <= rom_addr;
    rl2 <= rl1;
  end
  assign rom_data = rl2[11:0];

  int n_chk = 0, n_fail = 0;
  int k = 0, n = 0;
  bit fs_exp = 1'b0;
  int fs_cnt = 0, hs_low = 0, vs_low = 0;
  logic [16:0] a_h [4096];
  logic        b_h [4096];
  logic        d_h [4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] colour_at(input int p, input logic nb,
                                            input logic [11:0] rd, input logic dk);
    logic [11:0] c;
    if (!((p % HT) < HA && (p / HT) < VA)) c = 12'h000;
    else if (!nb || rd == 12'hF0F)         c = 12'h000;
    else                                    c = rd;
    if (dk)
      for (int i = 0; i < 3; i++) c[4*i +: 4] = c[4*i +: 4] / 2;
    return c;
  endfunction

  task automatic check_all();
    int p, q;
    logic [11:0] e_rgb;
    logic e_hs, e_vs;
    p = n % FT;
    chk("h_cnt", h_cnt, p % HT);
    chk("v_cnt", v_cnt, p / HT);
    chk("pix_en", pix_en, (k % CD) == CD - 1);
    chk("frame_start", frame_start, fs_exp);
    chk("rom_addr", rom_addr, (n == 0) ? 17'h0 : a_h[n % 4096]);
    if (n >= 2) begin
      q     = (n - 2) % FT;
      e_rgb = colour_at(q, b_h[(n-1) % 4096], a_h[(n-1) % 4096][11:0], d_h[n % 4096]);
      e_hs  = !((q % HT) >= HA + HF && (q % HT) < HA + HF + HS);
      e_vs  = !((q / HT) >= VA + VF && (q / HT) < VA + VF + VS);
    end else begin
      e_rgb = 12'h000;
      e_hs  = 1'b1;
      e_vs  = 1'b1;
    end
    chk("rgb", {vgaRed, vgaGreen, vgaBlue}, e_rgb);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
  endtask

  task automatic tick();
    bit pe;
    @(posedge clk);
    pe = (k % CD) == CD - 1;
    k++;
    fs_exp = 1'b0;
    if (pe) begin
      n++;
      a_h[n % 4096] = pixel_addr;
      b_h[n % 4096] = notBlank;
      d_h[n % 4096] = isDark;
      fs_exp = (n % FT) == 0;
    end
    @(negedge clk);
    check_all();
    if (frame_start) fs_cnt++;
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
  endtask

  task automatic rnd();
    pixel_addr = ($urandom_range(0, 3) == 0) ? {5'($urandom), 12'hF0F} : 17'($urandom);
    notBlank   = $urandom_range(0, 3) != 0;
    isDark     = 1'($urandom_range(0, 1));
  endtask

  // Tick until raster position pos is on the pins, just after its stage-2 strobe.
  task automatic wait_disp(input int pos);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!(n >= 2 && (n - 2) % FT == pos && k % CD == 0) && t < 3 * FT * CD);
    if (t >= 3 * FT * CD) chk("wait_disp_timeout", 1, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    k = 0; n = 0;
    check_all();

    for (int i = 0; i < 2 * FT * CD + 777; i++) begin
      rnd();
      tick();
      if (n_fail > 40) break;
    end
    chk("frame_cnt", fs_cnt, n / FT);

    t = 0;
    while (!frame_start && t < 2 * FT * CD) begin rnd(); tick(); t++; end
    hs_low = 0; vs_low = 0;
    for (int i = 0; i < FT * CD; i++) begin rnd(); tick(); end
    chk("hsync_low_clks", hs_low, HS * CD * VT);
    chk("vsync_low_clks", vs_low, VS * HT * CD);

    pixel_addr = 17'h00123; notBlank = 1'b1; isDark = 1'b0;
    wait_disp(0);
    chk("rgb_p0", {vgaRed, vgaGreen, vgaBlue}, 12'h123);
    chk("rom_addr_hold", rom_addr, 17'h00123);
    pixel_addr = 17'h00F0F;
    wait_disp(HT + 3);
    chk("transparent", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    pixel_addr = 17'h00ABC; notBlank = 1'b0;
    wait_disp(2 * HT + 5);
    chk("not_blank", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    pixel_addr = 17'h00FFF; notBlank = 1'b1;
    wait_disp(HA - 1);
    chk("last_active", {vgaRed, vgaGreen, vgaBlue}, 12'hFFF);
    wait_disp(HA + 4);
    chk("h_blank", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    pixel_addr = 17'h00E84; isDark = 1'b1;
    wait_disp(HT + 1);
    chk("dark_e84", {vgaRed, vgaGreen, vgaBlue}, 12'h742);

    t = 0;
    while ((n % FT) / HT != 4 && t < 2 * FT * CD) begin rnd(); tick(); t++; end
    chk("reach_mid_frame", (n % FT) / HT, 4);
    repeat (7) begin rnd(); tick(); end
    rst = 1'b1;
    #1;
    chk("rst_h", h_cnt, 0);
    chk("rst_v", v_cnt, 0);
    chk("rst_hs", hsync, 1);
    chk("rst_vs", vsync, 1);
    chk("rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pix_en", pix_en, 0);
    repeat (2) @(negedge clk);
    k = 0; n = 0; fs_exp = 1'b0;
    rst = 1'b0;
    check_all();
    t = 0;
    fs_cnt = 0;
    while (fs_cnt == 0 && t < 2 * FT * CD) begin rnd(); tick(); t++; end
    chk("fs_after_rst", t, FT * CD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
